// File: rtl/proc_core_if.sv
// Bus bundle between proc_core and its instruction/data memories.
// The core is the master; the memory subsystem plus DIN mux is the slave.
interface proc_core_if;
    logic [15:0] DIN;
    logic [15:0] DOUT;
    logic        Run;
    logic        Done;
    logic        W;
    logic        qControl;
    logic [2:0]  Tstep_Q;
    logic [5:0]  addr1;
    logic [5:0]  addr2;

    modport master (
        input  DIN, Run,
        output DOUT, Done, W, qControl, Tstep_Q, addr1, addr2
    );

    modport slave (
        output DIN, Run,
        input  DOUT, Done, W, qControl, Tstep_Q, addr1, addr2
    );
endinterface

// File: rtl/proc_core.sv
// Multi-cycle 16-bit core: eight registers, steps T0..T4, separate instruction
// and data memory address buses, synchronous-read external memories.
module proc_core (
    input  logic       Clock,
    input  logic       Reset,
    proc_core_if.master bus
);
    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_t;

    localparam logic [3:0] OP_MV   = 4'd0;
    localparam logic [3:0] OP_MVI  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_LD   = 4'd4;
    localparam logic [3:0] OP_ST   = 4'd5;
    localparam logic [3:0] OP_MVNZ = 4'd6;

    step_t       step_q;
    logic [15:0] regFile_q [8];
    logic [15:0] a_q;
    logic [15:0] g_q;
    logic [15:0] ir_q;
    logic [15:0] dout_q;
    logic [5:0]  pc_q;
    logic [5:0]  addr1_q;

    logic [3:0]  opcode;
    logic [2:0]  rx;
    logic [2:0]  ry;
    logic [15:0] rxVal;
    logic [15:0] ryVal;
    logic        doneStep;
    logic        unusedIrBits;

    assign opcode       = ir_q[15:12];
    assign rx           = ir_q[11:9];
    assign ry           = ir_q[8:6];
    assign rxVal        = regFile_q[rx];
    assign ryVal        = regFile_q[ry];
    assign unusedIrBits = ^ir_q[5:0];

    // Final step of each instruction class; opcodes 7-15 finish as nops in T2.
    always_comb begin
        doneStep = 1'b0;
        case (step_q)
            T2:      doneStep = (opcode == OP_MV) || (opcode == OP_MVNZ) || (opcode > OP_MVNZ);
            T3:      doneStep = (opcode == OP_MVI) || (opcode == OP_ST);
            T4:      doneStep = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_LD);
            default: doneStep = 1'b0;
        endcase
    end

    // Done and W are masked during Reset so an aborted store never reaches memory.
    assign bus.Done     = doneStep && !Reset;
    assign bus.W        = (step_q == T3) && (opcode == OP_ST) && !Reset;
    assign bus.qControl = (step_q == T4) && (opcode == OP_LD);
    assign bus.Tstep_Q  = step_q;
    assign bus.addr1    = addr1_q;
    assign bus.addr2    = pc_q;
    assign bus.DOUT     = dout_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            step_q  <= T0;
            a_q     <= '0;
            g_q     <= '0;
            ir_q    <= '0;
            dout_q  <= '0;
            pc_q    <= '0;
            addr1_q <= '0;
            for (int i = 0; i < 8; i++) regFile_q[i] <= '0;
        end else begin
            case (step_q)
                T0: begin
                    if (bus.Run) begin
                        pc_q   <= pc_q + 6'd1;
                        step_q <= T1;
                    end
                end
                T1: begin
                    ir_q   <= bus.DIN;
                    step_q <= T2;
                end
                T2: begin
                    case (opcode)
                        OP_MV: begin
                            regFile_q[rx] <= ryVal;
                            step_q        <= T0;
                        end
                        OP_MVNZ: begin
                            if (g_q != 16'd0) regFile_q[rx] <= ryVal;
                            step_q <= T0;
                        end
                        OP_MVI: begin
                            pc_q   <= pc_q + 6'd1;
                            step_q <= T3;
                        end
                        OP_ADD, OP_SUB: begin
                            a_q    <= rxVal;
                            step_q <= T3;
                        end
                        OP_LD: begin
                            addr1_q <= ryVal[5:0];
                            step_q  <= T3;
                        end
                        OP_ST: begin
                            addr1_q <= ryVal[5:0];
                            dout_q  <= rxVal;
                            step_q  <= T3;
                        end
                        default: step_q <= T0;
                    endcase
                end
                T3: begin
                    case (opcode)
                        OP_MVI: begin
                            regFile_q[rx] <= bus.DIN;
                            step_q        <= T0;
                        end
                        OP_ADD: begin
                            g_q    <= a_q + ryVal;
                            step_q <= T4;
                        end
                        OP_SUB: begin
                            g_q    <= a_q - ryVal;
                            step_q <= T4;
                        end
                        OP_LD:   step_q <= T4;
                        default: step_q <= T0;
                    endcase
                end
                T4: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) regFile_q[rx] <= g_q;
                    else if (opcode == OP_LD) regFile_q[rx] <= bus.DIN;
                    step_q <= T0;
                end
                default: step_q <= T0;
            endcase
        end
    end
endmodule

// File: tb/tb_proc_core.sv
// Directed bench for proc_core: models both memories and the DIN mux, runs a
// short hand-assembled program and checks registers and bus outputs.
module tb_proc_core;
    logic Clock = 1'b0;
    logic Reset = 1'b1;

    proc_core_if bus ();

    proc_core dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    logic [15:0] imem [64];
    logic [15:0] dmem [64];
    logic [15:0] iq = '0;
    logic [15:0] dq = '0;

    // Synchronous-read memories: q reflects the address sampled at the last edge.
    always @(posedge Clock) begin
        iq <= imem[bus.addr2];
        dq <= dmem[bus.addr1];
        if (bus.W) dmem[bus.addr1] <= bus.DOUT;
    end

    assign bus.DIN = bus.qControl ? dq : iq;

    int wCount = 0;
    always @(negedge Clock) begin
        if (bus.W === 1'b1) wCount++;
    end

    int assertCount = 0;
    int failCount   = 0;

    logic [15:0] doneW, doneAddr1, doneDout, doneQc;
    int          wBefore;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Runs one instruction to its Done step, then one more edge so its writes are visible.
    task automatic applyStimulus(input string tag, input logic [2:0] expStep);
        int  n         = 0;
        bit  doneSeen  = 1'b0;
        while (!doneSeen && n < 20) begin
            @(negedge Clock);
            n++;
            if (bus.Done === 1'b1) doneSeen = 1'b1;
        end
        checkOutput({tag, "_done"}, 16'(doneSeen), 16'd1);
        checkOutput({tag, "_doneStep"}, 16'(bus.Tstep_Q), 16'(expStep));
        doneW     = 16'(bus.W);
        doneAddr1 = 16'(bus.addr1);
        doneDout  = bus.DOUT;
        doneQc    = 16'(bus.qControl);
        @(negedge Clock);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) imem[i] = 16'h7000;
        imem[0]  = 16'h1000; imem[1]  = 16'h0005;
        imem[2]  = 16'h1200; imem[3]  = 16'h0003;
        imem[4]  = 16'h2040;
        imem[5]  = 16'h3040;
        imem[6]  = 16'h1400; imem[7]  = 16'h000A;
        imem[8]  = 16'h5080;
        imem[9]  = 16'h4680;
        imem[10] = 16'h3240;
        imem[11] = 16'h6800;
        imem[12] = 16'h1200; imem[13] = 16'h0003;
        imem[14] = 16'h2040;
        imem[15] = 16'h6800;
        imem[16] = 16'h1C00; imem[17] = 16'h0001;
        imem[18] = 16'h3B80;
        imem[63] = 16'h1E00;

        bus.Run = 1'b0;
        repeat (2) @(negedge Clock);
        checkOutput("rst_step",  16'(bus.Tstep_Q),  16'd0);
        checkOutput("rst_done",  16'(bus.Done),     16'd0);
        checkOutput("rst_w",     16'(bus.W),        16'd0);
        checkOutput("rst_qc",    16'(bus.qControl), 16'd0);
        checkOutput("rst_addr1", 16'(bus.addr1),    16'd0);
        checkOutput("rst_addr2", 16'(bus.addr2),    16'd0);
        checkOutput("rst_dout",  bus.DOUT,          16'd0);
        checkOutput("rst_r0",    dut.regFile_q[0],  16'd0);
        Reset   = 1'b0;
        bus.Run = 1'b1;

        applyStimulus("mvi_r0", 3'd3);
        checkOutput("mvi_r0_val", dut.regFile_q[0], 16'd5);
        checkOutput("mvi_r0_pc",  16'(bus.addr2),   16'd2);

        applyStimulus("mvi_r1", 3'd3);
        checkOutput("mvi_r1_val", dut.regFile_q[1], 16'd3);

        applyStimulus("add_r0r1", 3'd4);
        checkOutput("add_r0_val", dut.regFile_q[0], 16'd8);
        checkOutput("add_g_val",  dut.g_q,          16'd8);

        applyStimulus("sub_r0r1", 3'd4);
        checkOutput("sub_r0_val", dut.regFile_q[0], 16'd5);

        applyStimulus("mvi_r2", 3'd3);
        checkOutput("mvi_r2_val", dut.regFile_q[2], 16'd10);

        wBefore = wCount;
        applyStimulus("st_r0", 3'd3);
        checkOutput("st_w_at_t3", doneW,      16'd1);
        checkOutput("st_addr1",   doneAddr1,  16'd10);
        checkOutput("st_dout",    doneDout,   16'd5);
        checkOutput("st_w_count", 16'(wCount - wBefore), 16'd1);
        checkOutput("st_mem",     dmem[10],   16'd5);

        applyStimulus("ld_r3", 3'd4);
        checkOutput("ld_qc_at_t4", doneQc,           16'd1);
        checkOutput("ld_r3_val",   dut.regFile_q[3], 16'd5);
        checkOutput("ld_qc_after", 16'(bus.qControl), 16'd0);

        applyStimulus("sub_r1r1", 3'd4);
        checkOutput("sub_r1_zero", dut.regFile_q[1], 16'd0);
        checkOutput("sub_g_zero",  dut.g_q,          16'd0);

        applyStimulus("mvnz_g0", 3'd2);
        checkOutput("mvnz_g0_r4", dut.regFile_q[4], 16'd0);

        applyStimulus("mvi_r1_again", 3'd3);
        applyStimulus("add_r0r1_again", 3'd4);
        checkOutput("add2_r0_val", dut.regFile_q[0], 16'd8);

        applyStimulus("mvnz_g8", 3'd2);
        checkOutput("mvnz_g8_r4", dut.regFile_q[4], 16'd8);

        applyStimulus("mvi_r6", 3'd3);
        applyStimulus("sub_wrap", 3'd4);
        checkOutput("sub_wrap_r5", dut.regFile_q[5], 16'hFFFF);

        for (int k = 0; k < 44; k++) applyStimulus("nop", 3'd2);
        checkOutput("nop_pc63", 16'(bus.addr2), 16'd63);
        checkOutput("nop_r5_kept", dut.regFile_q[5], 16'hFFFF);

        applyStimulus("mvi_pc63", 3'd3);
        checkOutput("mvi_pc63_r7", dut.regFile_q[7], 16'h1000);
        checkOutput("mvi_pc63_pc", 16'(bus.addr2),   16'd1);

        bus.Run = 1'b0;
        repeat (5) @(negedge Clock);
        checkOutput("idle_step", 16'(bus.Tstep_Q), 16'd0);
        checkOutput("idle_pc",   16'(bus.addr2),   16'd1);
        checkOutput("idle_done", 16'(bus.Done),    16'd0);
        bus.Run = 1'b1;

        applyStimulus("mv_r0r0", 3'd2);
        checkOutput("mv_r0_val", dut.regFile_q[0], 16'd8);
        applyStimulus("mvi_r1_third", 3'd3);
        checkOutput("pre_add_pc", 16'(bus.addr2), 16'd4);

        begin
            int n = 0;
            while (bus.Tstep_Q !== 3'd3 && n < 20) begin
                @(negedge Clock);
                n++;
            end
        end
        checkOutput("add_reach_t3", 16'(bus.Tstep_Q), 16'd3);
        Reset = 1'b1;
        @(negedge Clock);
        checkOutput("abort_step", 16'(bus.Tstep_Q), 16'd0);
        checkOutput("abort_r0",   dut.regFile_q[0], 16'd0);
        checkOutput("abort_pc",   16'(bus.addr2),   16'd0);
        checkOutput("abort_done", 16'(bus.Done),    16'd0);
        Reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
